l2_tagarb: RTL and testbench

L2_TAGARB -- requirements
Module: l2_tagarb

---
 rtl/l2_tagarb_pkg.sv | 35 +++
 rtl/l2_tagarb_if.sv | 30 +++
 rtl/l2_tagarb_beatcnt.sv | 44 ++++
 rtl/l2_tagarb.sv | 90 +++++++++
 tb/tb_l2_tagarb.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/l2_tagarb_pkg.sv
// Shared L2 definitions: bus command codes, tag/data arbiter state encoding and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l2_tagarb_pkg;

  // Bus-receive command codes carried alongside recv_req by the bus interface.
  typedef enum logic [1:0] {
    BUSCMD_NOP   = 2'd0,
    BUSCMD_FILL  = 2'd1,
    BUSCMD_INV   = 2'd2,
    BUSCMD_FLUSH = 2'd3
  } buscmd_e;

  localparam int L2_FILL_BEATS = 8;  // 8B beats per line fill
  localparam int L2_STARVE_MAX = 3;  // recv grants tolerated while fifo waits
  localparam int L2_BEAT_W     = 3;
  localparam int L2_STARVE_W   = 2;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_RECV_OP = 3'd1,
    ARB_FILL    = 3'd2,
    ARB_FIFO_RD = 3'd3,
    ARB_FIFO_WR = 3'd4
  } arb_state_e;

  function automatic logic is_recv_state(arb_state_e s);
    return (s == ARB_RECV_OP) || (s == ARB_FILL);
  endfunction

  function automatic logic is_fifo_state(arb_state_e s);
    return (s == ARB_FIFO_RD) || (s == ARB_FIFO_WR);
  endfunction

endpackage

// File: rtl/l2_tagarb_if.sv
// Request/grant bundle between the recv path, request FIFO and the L2 tag arbiter.
// Latency: n/a (wires only).
// Backpressure: resp_ready gates fifo eligibility; pop pulse l2_l2reqfifo_ready returns to the FIFO.
// Ports: master = requester side (drives req/qualifiers), slave = arbiter side (drives grants/status).
interface l2_tagarb_if;
  import l2_tagarb_pkg::*;

  logic                   recv_req;
  logic                   recv_fill;
  logic                   fifo_req;
  logic                   fifo_wen;
  logic                   resp_ready;
  logic                   arb_recv_grant;
  logic                   arb_fifo_grant;
  logic                   l2_l2reqfifo_ready;
  logic                   arb_busy;
  logic [L2_BEAT_W-1:0]   arb_beat;
  logic [L2_STARVE_W-1:0] arb_starve;

  modport master (
    output recv_req, recv_fill, fifo_req, fifo_wen, resp_ready,
    input  arb_recv_grant, arb_fifo_grant, l2_l2reqfifo_ready, arb_busy, arb_beat, arb_starve
  );

  modport slave (
    input  recv_req, recv_fill, fifo_req, fifo_wen, resp_ready,
    output arb_recv_grant, arb_fifo_grant, l2_l2reqfifo_ready, arb_busy, arb_beat, arb_starve
  );

endinterface

// File: rtl/l2_tagarb_beatcnt.sv
// Loadable beat counter: remaining-beats down-counter with an up-running beat index and last flag.
// Latency: load takes effect on the next cycle; last is a decode of the registered count.
// Backpressure: none; counts down unconditionally until the last beat, then holds.
// Ports: clk, rst (async active-low), load/load_val (beats-1), idx (0-based beat), last.
module l2_tagarb_beatcnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] idx,
  output logic         last
);

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] idx_q, idx_d;

  always_comb begin
    rem_d = rem_q;
    idx_d = idx_q;
    if (load) begin
      rem_d = load_val;
      idx_d = '0;
    end else if (rem_q != '0) begin
      rem_d = rem_q - 1'b1;
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      idx_q <= '0;
    end else begin
      rem_q <= rem_d;
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign last = (rem_q == '0);

endmodule

// File: rtl/l2_tagarb.sv
// L2 tag/data pipeline arbiter between bus-receive ops and the request FIFO, with starvation guard.
// Latency: 1 cycle from sampled request to grant; back-to-back ops with no bubble.
// Backpressure: fifo only eligible with resp_ready; granted ops always run to completion.
// Ports: clk, rst (async active-low), bus (slave modport: req/qualifiers in, grants/beat/starve out).
module l2_tagarb
  import l2_tagarb_pkg::*;
#(
  parameter int FILL_BEATS = L2_FILL_BEATS,
  parameter int STARVE_MAX = L2_STARVE_MAX
) (
  input logic        clk,
  input logic        rst,
  l2_tagarb_if.slave bus
);

  localparam logic [L2_BEAT_W-1:0]   FILL_LAST  = L2_BEAT_W'(FILL_BEATS - 1);
  localparam logic [L2_STARVE_W-1:0] STARVE_TOP = L2_STARVE_W'(STARVE_MAX);

  arb_state_e             state_q, state_d;
  logic [L2_STARVE_W-1:0] starve_q, starve_d;
  logic [L2_BEAT_W-1:0]   load_val;
  logic [L2_BEAT_W-1:0]   beat_idx;
  logic                   beat_last;
  logic                   fifo_elig;
  logic                   starve_full;
  logic                   take_recv;
  logic                   take_fifo;
  logic                   recv_g;
  logic                   fifo_g;

  // The counter reads "last" in IDLE too, so the decision point is simply
  // the last beat; it reloads every decision cycle (0 when going idle).
  l2_tagarb_beatcnt #(.W(L2_BEAT_W)) u_beatcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (beat_last),
    .load_val (load_val),
    .idx      (beat_idx),
    .last     (beat_last)
  );

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    load_val    = '0;
    take_recv   = 1'b0;
    take_fifo   = 1'b0;
    fifo_elig   = bus.fifo_req & bus.resp_ready;
    starve_full = (starve_q == STARVE_TOP);
    if (beat_last) begin
      // recv wins unless the fifo has been passed over STARVE_MAX times and can go now.
      take_recv = bus.recv_req & ~(starve_full & fifo_elig);
      take_fifo = ~take_recv & fifo_elig;
      if (take_recv) begin
        state_d  = bus.recv_fill ? ARB_FILL : ARB_RECV_OP;
        load_val = bus.recv_fill ? FILL_LAST : '0;
        if (fifo_elig && !starve_full) begin
          starve_d = starve_q + 1'b1;
        end
      end else if (take_fifo) begin
        state_d  = bus.fifo_wen ? ARB_FIFO_WR : ARB_FIFO_RD;
        load_val = bus.fifo_wen ? L2_BEAT_W'(1) : '0;
        starve_d = '0;
      end else begin
        state_d = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Outputs decode registered state only.
  assign recv_g                 = is_recv_state(state_q);
  assign fifo_g                 = is_fifo_state(state_q);
  assign bus.arb_recv_grant     = recv_g;
  assign bus.arb_fifo_grant     = fifo_g;
  assign bus.l2_l2reqfifo_ready = fifo_g & (beat_idx == '0);
  assign bus.arb_busy           = recv_g | fifo_g;
  assign bus.arb_beat           = beat_idx;
  assign bus.arb_starve         = starve_q;

endmodule

// File: tb/tb_l2_tagarb.sv
// Self-checking bench for l2_tagarb: directed scenarios plus random traffic against a queue-based model.
// Latency: model expects the first op cycle one clock after the requests are sampled.
// Backpressure: resp_ready randomised to exercise fifo eligibility.
module tb_l2_tagarb;
  import l2_tagarb_pkg::*;

  localparam int FB = 8;
  localparam int SM = 3;

  typedef struct packed {
    logic       recv;
    logic       fifo;
    logic       pop;
    logic       busy;
    logic [2:0] beat;
    logic [1:0] starve;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_tagarb_if bus_if ();

  l2_tagarb #(.FILL_BEATS(FB), .STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  exp_t exp_q[$];
  int   starve_m;
  exp_t last_obs;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  function automatic exp_t observe();
    exp_t o;
    o.recv   = bus_if.arb_recv_grant;
    o.fifo   = bus_if.arb_fifo_grant;
    o.pop    = bus_if.l2_l2reqfifo_ready;
    o.busy   = bus_if.arb_busy;
    o.beat   = bus_if.arb_beat;
    o.starve = bus_if.arb_starve;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: an op is a list of per-cycle output tuples appended to a queue
  // when the arbiter is free (queue drained).
  task automatic model_decide(input logic r, input logic rf, input logic f,
                              input logic fw, input logic rr);
    logic elig;
    int   n;
    exp_t e;
    elig = f & rr;
    if (r && !(elig && starve_m == SM)) begin
      if (elig && starve_m < SM) starve_m++;
      n = rf ? FB : 1;
      for (int i = 0; i < n; i++) begin
        e = '{recv: 1'b1, fifo: 1'b0, pop: 1'b0, busy: 1'b1, beat: 3'(i), starve: 2'(starve_m)};
        exp_q.push_back(e);
      end
    end else if (elig) begin
      starve_m = 0;
      n = fw ? 2 : 1;
      for (int i = 0; i < n; i++) begin
        e = '{recv: 1'b0, fifo: 1'b1, pop: (i == 0), busy: 1'b1, beat: 3'(i), starve: 2'd0};
        exp_q.push_back(e);
      end
    end else begin
      e = '{recv: 1'b0, fifo: 1'b0, pop: 1'b0, busy: 1'b0, beat: 3'd0, starve: 2'(starve_m)};
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_decide(input logic r, input logic rf, input logic f,
                              input logic fw, input logic rr);
    bus_if.recv_req   = r;
    bus_if.recv_fill  = rf;
    bus_if.fifo_req   = f;
    bus_if.fifo_wen   = fw;
    bus_if.resp_ready = rr;
    if (exp_q.size() == 0) model_decide(r, rf, f, fw, rr);
  endtask

  // Check this cycle's outputs, then drive the inputs the next edge will sample.
  task automatic step(input string tag, input logic r, input logic rf, input logic f,
                      input logic fw, input logic rr);
    exp_t e;
    @(negedge clk);
    last_obs = observe();
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = '0;
    check(tag, 32'(last_obs), 32'(e));
    drive_decide(r, rf, f, fw, rr);
  endtask

  int cnt_a;
  int cnt_b;
  int first_pop;
  logic [1:0] starve_tbl [8];

  initial begin
    starve_tbl = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1;
    bus_if.recv_req   = 1'b0;
    bus_if.recv_fill  = 1'b0;
    bus_if.fifo_req   = 1'b0;
    bus_if.fifo_wen   = 1'b0;
    bus_if.resp_ready = 1'b0;
    #1 rst = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(observe()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    starve_m = 0;
    drive_decide(0, 0, 0, 0, 0);
    step("idle_after_reset", 0, 0, 0, 0, 0);

    // Lone line fill: 8 recv beats then idle
    step("fill_req", 1, 1, 0, 0, 0);
    cnt_a = 0;
    for (int i = 0; i < FB + 2; i++) begin
      step("fill_beat", 0, 0, 0, 0, 0);
      if (last_obs.recv) cnt_a++;
    end
    check("fill_grant_cycles", 32'(cnt_a), 32'(FB));
    check("fill_then_idle", 32'(last_obs.busy), 32'd0);

    // FIFO write: 2 grant cycles, pop only in the first
    step("wr_req", 0, 0, 1, 1, 1);
    cnt_a = 0; cnt_b = 0; first_pop = -1;
    for (int i = 0; i < 3; i++) begin
      step("wr_beat", 0, 0, 0, 0, 0);
      if (last_obs.fifo) cnt_a++;
      if (last_obs.pop) begin
        cnt_b++;
        if (first_pop < 0) first_pop = i;
      end
    end
    check("wr_grant_cycles", 32'(cnt_a), 32'd2);
    check("wr_pop_count", 32'(cnt_b), 32'd1);
    check("wr_pop_first_beat", 32'(first_pop), 32'd0);

    // Continuous contention: recv,recv,recv,fifo with starve 1,2,3,0
    step("starve_start", 1, 0, 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step("starve_cyc", 1, 0, 1, 0, 1);
      check("starve_value", 32'(last_obs.starve), 32'(starve_tbl[i]));
      check("starve_fifo_slot", 32'(last_obs.fifo), 32'(i % 4 == 3));
    end
    repeat (3) step("starve_drain", 0, 0, 0, 0, 0);

    // FIFO read, then recv op requested on its last beat: no bubble
    step("rd_req", 0, 0, 1, 0, 1);
    step("rd_beat", 1, 0, 1, 0, 0);
    check("rd_granted", 32'(last_obs.fifo), 32'd1);
    // Ineligible fifo (resp_ready low): recv every cycle, no starvation, no pop
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 7; i++) begin
      step("inelig_cyc", 1, 0, 1, 0, 0);
      if (i == 0) check("no_bubble_recv", 32'(last_obs.recv), 32'd1);
      if (last_obs.recv) cnt_a++;
      if (last_obs.pop || last_obs.starve != 2'd0) cnt_b++;
    end
    check("inelig_recv_cycles", 32'(cnt_a), 32'd7);
    check("inelig_no_pop_starve", 32'(cnt_b), 32'd0);
    repeat (2) step("inelig_drain", 0, 0, 0, 0, 0);

    // Reset at fill beat 4, then re-grant from beat 0
    step("fill2_req", 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("fill2_beat", 1, 1, 0, 0, 0);
    check("fill2_at_beat4", 32'(last_obs.beat), 32'd4);
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", 32'(observe()), 32'd0);
    exp_q.delete();
    starve_m = 0;
    @(negedge clk);
    check("reset_held_outputs", 32'(observe()), 32'd0);
    rst = 1'b1;
    drive_decide(1, 1, 0, 0, 0);
    step("fill3_beat", 0, 0, 0, 0, 0);
    check("regrant_beat0", 32'({last_obs.recv, last_obs.beat}), 32'({1'b1, 3'd0}));
    for (int i = 1; i < FB + 1; i++) step("fill3_beat", 0, 0, 0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step("random",
           1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 25),
           1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 70));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
